exp_sigmoid_div: RTL and testbench

Sequential normaliser that sits directly downstream of the exponent stage in the neuron datapath. It takes the non-negative power value P (signed Q11.9, 21 bit) and returns y = P / (P + 1.0) in Q11.9, the logistic form used for neuron activation. The quotient is computed with a 9-iteration restoring divider behind valid/ready handshakes on both sides.

---
 rtl/exp_sigmoid_div.sv | 135 +++++++++++++
 tb/tb_exp_sigmoid_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exp_sigmoid_div.sv
// -----------------------------------------------------------------------------
// exp_sigmoid_div
//
// Logistic normaliser for the neuron datapath. Takes a non-negative power
// value P (signed Q11.9) from the exponent stage and returns
// y = P / (P + 1.0) in Q11.9 using a FRAC_BITS-iteration restoring divider.
// Negative inputs are clamped to zero. The result always lies in [0, 511/512].
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_power carries an operand
//   in_ready   block can accept an operand (IDLE only)
//   in_power   signed Q11.9 power value
//   out_valid  out_y holds a finished result
//   out_ready  consumer accepts the result
//   out_y      signed Q11.9 result, never negative, always below 1.0
//   busy       a divide is in flight or its result is pending
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready high
// DIV   | one restoring-divide iteration per clock
// DONE  | result registered on out_y, waiting for the output handshake
// -----------------------------------------------------------------------------
module exp_sigmoid_div #(
  parameter int WIDTH     = 21,
  parameter int FRAC_BITS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_power,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  // One extra bit over WIDTH: D = P + 1.0 can exceed the positive range of
  // WIDTH bits, and the doubled remainder must fit without wrapping.
  localparam int RW = WIDTH + 1;
  localparam int CW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [RW-1:0] ONE      = {{(RW-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAC_BITS - 1);

  logic [1:0]           state;
  logic [RW-1:0]        rem;
  logic [RW-1:0]        den;
  logic [FRAC_BITS-1:0] quo;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     p_clamp;
  logic [RW-1:0]        p_ext;
  logic [RW-1:0]        rem_dbl;
  logic                 q_bit;
  logic [RW-1:0]        rem_next;
  logic [FRAC_BITS-1:0] quo_next;
  logic                 accept;
  logic                 release_out;

  // Handshake decode is from state (and reset) only, so there is no
  // combinational path from in_valid or out_ready to any output.
  assign in_ready    = (state == ST_IDLE) & ~rst;
  assign busy        = (state == ST_DIV) | (state == ST_DONE);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;

  // Operand conditioning: negative powers are meaningless here, treat as 0.
  assign p_clamp = in_power[WIDTH-1] ? '0 : in_power;
  assign p_ext   = {1'b0, p_clamp};

  // Restoring divide step. Starting with rem = P < den = P + 1.0 keeps
  // rem < den on every iteration, so the doubled remainder never overflows.
  assign rem_dbl  = rem << 1;
  assign q_bit    = (rem_dbl >= den);
  assign rem_next = q_bit ? (rem_dbl - den) : rem_dbl;
  assign quo_next = {quo[FRAC_BITS-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      den       <= '0;
      quo       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rem   <= p_ext;
            den   <= p_ext + ONE;
            quo   <= '0;
            cnt   <= CNT_LAST;
            state <= ST_DIV;
          end
        end

        ST_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == '0) begin
            // Result lands on out_y only here; it is held until the next one.
            out_y     <= {{(WIDTH-FRAC_BITS){1'b0}}, quo_next};
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          if (release_out) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sigmoid_div.sv
module tb_exp_sigmoid_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_power;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_y;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int sb[$];
  int n_in  = 0;
  int n_out = 0;
  bit stream_mode = 1'b0;

  exp_sigmoid_div #(.WIDTH(21), .FRAC_BITS(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_power  (in_power),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [20:0] p);
    longint pp;
    if (p[20]) return 0;
    pp = longint'(p);
    return int'((pp * 512) / (pp + 512));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (stream_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer p until accepted; push the expected result at the accepting edge.
  task automatic send(input logic [20:0] p, input int expv, input bit push, input bit keep);
    in_power = p;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      tick();
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      if (push) begin
        sb.push_back(expv);
        n_in++;
      end
      tick();
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, sb.size(), 0);
  endtask

  // Output side of the scoreboard: every output handshake pops one entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected observed=%0d expected=none", out_y);
      end else begin
        check("out_y", out_y, sb.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_power  = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Unity input with exact latency
    out_ready = 1'b1;
    send(21'd512, 256, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("lat_out_valid_low", out_valid, 0);
    end
    tick();
    check("lat_out_valid_e9", out_valid, 1);
    check("lat_out_y_e9", out_y, 256);
    check("lat_in_ready_e9", in_ready, 0);
    check("lat_busy_e9", busy, 1);
    tick();
    check("lat_in_ready_e10", in_ready, 1);
    check("lat_out_valid_e10", out_valid, 0);
    check("lat_busy_e10", busy, 0);
    check("lat_out_y_hold", out_y, 256);

    // Zero, negative, typical values, extreme
    send(21'd0, 0, 1'b1, 1'b0);
    drain("drain_zero", 40);
    send(21'h1FFFFB, 0, 1'b1, 1'b0);
    drain("drain_neg", 40);
    send(21'd1536, 384, 1'b1, 1'b0);
    drain("drain_1536", 40);
    send(21'd256, 170, 1'b1, 1'b0);
    drain("drain_256", 40);
    send(21'h0FFFFF, 511, 1'b1, 1'b0);
    drain("drain_max", 40);

    // Backpressure
    out_ready = 1'b0;
    send(21'd1536, 384, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    check("bp_out_valid_rise", out_valid, 1);
    in_valid = 1'b1;
    in_power = 21'd512;
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_y", out_y, 384);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    send(21'd512, 256, 1'b1, 1'b0);
    drain("drain_bp", 40);

    // Reset mid-divide: accept at E0, reset at E4
    send(21'd1536, 0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_after", in_ready, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("abort_no_result", out_valid, 0);
    end
    send(21'd512, 256, 1'b1, 1'b0);
    drain("drain_abort", 40);

    // Back-to-back stream with random backpressure
    stream_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [20:0] p;
      if (i % 3 == 0) p = 21'($urandom_range(0, 2047));
      else            p = 21'($urandom_range(0, 21'h0FFFFF));
      send(p, model(p), 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    drain("drain_stream", 3000);
    stream_mode = 1'b0;
    out_ready   = 1'b1;
    tick();
    check("stream_count", n_out, n_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
